// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter that shares one two-stage fp_mult among NUM_REQ requesters.
// Operands are held for both fp_mult cycles, and results come back on a shared bus with one-hot valid.
module fp_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [32*NUM_REQ-1:0]    req_a,
  input  logic [32*NUM_REQ-1:0]    req_b,
  input  logic [3*NUM_REQ-1:0]     req_rnd,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [31:0]              rsp_z,
  output logic [7:0]               rsp_status,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  output logic [2:0]               mul_rnd,
  input  logic [31:0]              mul_z,
  input  logic [7:0]               mul_status,
  output logic                     busy,
  output logic [15:0]              op_count,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid & ready are both high;
  // requesters hold valid and payload until ready, and responses stay on the bus until accepted.

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int SCAN_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_COLLECT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [2:0]         rnd_q;
  logic [TAG_W-1:0]   tag_q;
  logic [31:0]        z_q;
  logic [7:0]         status_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [15:0]        op_count_q;
  logic [15:0]        op_count_d;

  logic               rsp_accept;
  logic               arb_en;
  logic               grant;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_next;
  logic [SCAN_W-1:0]  scan;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [2:0]         sel_rnd;
  logic [TAG_W-1:0]   sel_tag;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + SCAN_W'(k);
      if (scan >= SCAN_W'(NUM_REQ)) scan = scan - SCAN_W'(NUM_REQ);
      if (!grant_found && req_valid[scan[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_rnd = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_rnd = req_rnd[3*i +: 3];
        sel_tag = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign rsp_accept = (state_q == S_RESP) && |(rsp_valid_q & rsp_ready);
  assign arb_en     = (state_q == S_IDLE) || rsp_accept;
  // ready is gated by rst so it reads zero for the whole reset, not only after the first edge
  assign grant      = rst && arb_en && grant_found;
  assign req_ready  = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rr_next    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign op_count_d = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rnd_q       <= '0;
      tag_q       <= '0;
      z_q         <= '0;
      status_q    <= '0;
      rsp_valid_q <= '0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          z_q         <= mul_z;
          status_q    <= mul_status;
          rsp_valid_q <= NUM_REQ'(1) << owner_q;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_accept) begin
            rsp_valid_q <= '0;
            op_count_q  <= op_count_d;
            state_q     <= grant ? S_ISSUE : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Operand registers move only on a grant, so fp_mult sees stable inputs across both stages.
      if (grant) begin
        a_q      <= sel_a;
        b_q      <= sel_b;
        rnd_q    <= sel_rnd;
        tag_q    <= sel_tag;
        owner_q  <= grant_idx;
        rr_ptr_q <= rr_next;
      end
    end
  end

  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_rnd    = rnd_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_z      = z_q;
  assign rsp_status = status_q;
  assign rsp_tag    = tag_q;
  assign busy       = (state_q != S_IDLE);
  assign op_count   = op_count_q;
  assign dbg_state  = state_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst) $onehot0(rsp_valid));
  a_no_grant_pending: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_RESP && !rsp_accept) |-> (req_ready == '0));

endmodule
